// File: rtl/fill_rect_data_gen_engine_p.sv
// Rectangle-fill write generator.
// Accepts one fill command at a time and emits one arbiter write per colour
// plane per pixel of a wid x hgt rectangle in a planar, packed framebuffer.
// Generation advances only on arbiter transfers (arb_out_rts & arb_in_rtr).
//
// Ports:
//   clk, rst_                  clock, asynchronous active-low reset
//   in_rts / out_rtr           command handshake with the decode stage
//   init_addr, init_lane       word address and packed lane of top-left pixel
//   cmd_data_hgt/wid           rectangle size in pixels
//   cmd_data_r/g/bval          fill colour components
//   cmd_outline                1 = draw border pixels only
//   arb_out_rts / arb_in_rtr   write request handshake with the arbiter
//   arb_out_addr/data/wben/op  write address, data, byte enables, op (1=write)
//   done_strobe                one-cycle pulse when a command completes
//
// state   | meaning
// S_IDLE  | ready for a command (out_rtr high one clk after reset/DONE)
// S_DRIVE | presenting writes to the arbiter
// S_DONE  | single completion cycle, done_strobe high
module fill_rect_data_gen_engine_p #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int COLOR_W    = 4,
  parameter int CNT_W      = 16,
  parameter int ROW_STRIDE = 240,
  parameter int PLANES     = 3,
  localparam int PPW       = DATA_W / COLOR_W,
  localparam int LANE_W    = (PPW > 1) ? $clog2(PPW) : 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               in_rts,
  output logic               out_rtr,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [LANE_W-1:0]  init_lane,
  input  logic [CNT_W-1:0]   cmd_data_hgt,
  input  logic [CNT_W-1:0]   cmd_data_wid,
  input  logic [COLOR_W-1:0] cmd_data_rval,
  input  logic [COLOR_W-1:0] cmd_data_gval,
  input  logic [COLOR_W-1:0] cmd_data_bval,
  input  logic               cmd_outline,
  output logic               arb_out_rts,
  input  logic               arb_in_rtr,
  output logic [ADDR_W-1:0]  arb_out_addr,
  output logic [DATA_W-1:0]  arb_out_data,
  output logic [BE_W-1:0]    arb_out_wben,
  output logic               arb_out_op,
  output logic               done_strobe
);

  localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int SH_W  = LANE_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   hgt_q, hgt_d, wid_q, wid_d, row_q, row_d, col_q, col_d;
  logic [PL_W-1:0]    plane_q, plane_d;
  logic [LANE_W-1:0]  lane_q, lane_d, lane0_q, lane0_d;
  logic [ADDR_W-1:0]  rowbase_q, rowbase_d, wordoff_q, wordoff_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               outline_q, outline_d;

  logic               accept, xfc, drive;
  logic               last_col, last_row, last_plane, interior_row;
  logic [CNT_W-1:0]   step;
  logic [SUM_W-1:0]   lane_sum, lane_wraps;
  logic [COLOR_W-1:0] comp;
  logic [SH_W-1:0]    bit_pos;

  assign drive        = (state_q == S_DRIVE);
  assign accept       = (state_q == S_IDLE) && rdy_q && in_rts;
  assign xfc          = arb_out_rts && arb_in_rtr;
  assign last_col     = (col_q == wid_q - CNT_W'(1));
  assign last_row     = (row_q == hgt_q - CNT_W'(1));
  assign last_plane   = (plane_q == PL_W'(PLANES - 1));
  assign interior_row = (row_q != '0) && !last_row;

  // Outline rows between top and bottom only touch the first and last column.
  assign step       = (outline_q && interior_row && (col_q == '0)) ?
                      (wid_q - CNT_W'(1)) : CNT_W'(1);
  // A column step may cross several packed words when it jumps a whole row.
  assign lane_sum   = SUM_W'(lane_q) + SUM_W'(step);
  assign lane_wraps = lane_sum / SUM_W'(PPW);

  always_comb begin
    comp = b_q;
    if (plane_q == PL_W'(0))      comp = r_q;
    else if (plane_q == PL_W'(1)) comp = g_q;
  end

  assign bit_pos      = SH_W'(lane_q) * SH_W'(COLOR_W);
  assign arb_out_rts  = drive;
  assign arb_out_op   = drive;
  assign done_strobe  = (state_q == S_DONE);
  assign out_rtr      = rdy_q;
  assign arb_out_addr = drive ? (rowbase_q + wordoff_q + ADDR_W'(plane_q)) : '0;
  assign arb_out_data = drive ? (DATA_W'(comp) << bit_pos) : '0;
  assign arb_out_wben = drive ? (BE_W'(1) << (bit_pos >> 3)) : '0;

  always_comb begin
    state_d   = state_q;
    rdy_d     = 1'b0;
    hgt_d     = hgt_q;
    wid_d     = wid_q;
    row_d     = row_q;
    col_d     = col_q;
    plane_d   = plane_q;
    lane_d    = lane_q;
    lane0_d   = lane0_q;
    rowbase_d = rowbase_q;
    wordoff_d = wordoff_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    outline_d = outline_q;
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d     = 1'b0;
          hgt_d     = cmd_data_hgt;
          wid_d     = cmd_data_wid;
          r_d       = cmd_data_rval;
          g_d       = cmd_data_gval;
          b_d       = cmd_data_bval;
          outline_d = cmd_outline;
          row_d     = '0;
          col_d     = '0;
          plane_d   = '0;
          lane_d    = init_lane;
          lane0_d   = init_lane;
          rowbase_d = init_addr;
          wordoff_d = '0;
          state_d   = ((cmd_data_hgt == '0) || (cmd_data_wid == '0)) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (xfc) begin
          if (!last_plane) begin
            plane_d = plane_q + PL_W'(1);
          end else begin
            plane_d = '0;
            if (last_col) begin
              if (last_row) begin
                state_d = S_DONE;
              end else begin
                col_d     = '0;
                row_d     = row_q + CNT_W'(1);
                lane_d    = lane0_q;
                wordoff_d = '0;
                rowbase_d = rowbase_q + ADDR_W'(ROW_STRIDE);
              end
            end else begin
              col_d     = col_q + step;
              lane_d    = LANE_W'(lane_sum % SUM_W'(PPW));
              wordoff_d = wordoff_q + ADDR_W'(lane_wraps * SUM_W'(PLANES));
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      hgt_q     <= '0;
      wid_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      plane_q   <= '0;
      lane_q    <= '0;
      lane0_q   <= '0;
      rowbase_q <= '0;
      wordoff_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      outline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      hgt_q     <= hgt_d;
      wid_q     <= wid_d;
      row_q     <= row_d;
      col_q     <= col_d;
      plane_q   <= plane_d;
      lane_q    <= lane_d;
      lane0_q   <= lane0_d;
      rowbase_q <= rowbase_d;
      wordoff_q <= wordoff_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      outline_q <= outline_d;
    end
  end

endmodule

// File: tb/tb_fill_rect_data_gen_engine_p.sv
module tb_fill_rect_data_gen_engine_p;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        in_rts = 1'b0;
  logic        out_rtr;
  logic [15:0] init_addr = '0;
  logic [2:0]  init_lane = '0;
  logic [15:0] cmd_data_hgt = '0, cmd_data_wid = '0;
  logic [3:0]  cmd_data_rval = '0, cmd_data_gval = '0, cmd_data_bval = '0;
  logic        cmd_outline = 1'b0;
  logic        arb_out_rts, arb_in_rtr = 1'b0;
  logic [15:0] arb_out_addr;
  logic [31:0] arb_out_data;
  logic [3:0]  arb_out_wben;
  logic        arb_out_op, done_strobe;

  always #5 clk = ~clk;

  fill_rect_data_gen_engine_p dut (
    .clk(clk), .rst_(rst_), .in_rts(in_rts), .out_rtr(out_rtr),
    .init_addr(init_addr), .init_lane(init_lane),
    .cmd_data_hgt(cmd_data_hgt), .cmd_data_wid(cmd_data_wid),
    .cmd_data_rval(cmd_data_rval), .cmd_data_gval(cmd_data_gval),
    .cmd_data_bval(cmd_data_bval), .cmd_outline(cmd_outline),
    .arb_out_rts(arb_out_rts), .arb_in_rtr(arb_in_rtr),
    .arb_out_addr(arb_out_addr), .arb_out_data(arb_out_data),
    .arb_out_wben(arb_out_wben), .arb_out_op(arb_out_op),
    .done_strobe(done_strobe)
  );

  typedef struct {
    int          hgt, wid;
    logic [15:0] addr;
    int          lane;
    logic [3:0]  r, g, b;
    bit          outline, rnd;
    int          nwr;
    logic [15:0] laddr;
    logic [31:0] ldata;
    logic [3:0]  lwben;
  } vec_t;

  int pass_cnt = 0, chk_cnt = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_xfc_cyc = 0;
  logic [51:0] obs_q[$], exp_q[$];
  logic [51:0] held;
  bit held_v = 0;
  bit rnd_rtr = 0;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [51:0] wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    return {a, d, b};
  endfunction

  // Monitor: records transfers, done pulses and checks stalled outputs stay put.
  always @(negedge clk) begin
    cyc++;
    if (rst_) begin
      if (arb_out_rts && held_v)
        chk("hold", wr(arb_out_addr, arb_out_data, arb_out_wben), held);
      held_v = arb_out_rts && !arb_in_rtr;
      held   = wr(arb_out_addr, arb_out_data, arb_out_wben);
      if (arb_out_rts && arb_in_rtr) begin
        obs_q.push_back(wr(arb_out_addr, arb_out_data, arb_out_wben));
        last_xfc_cyc = cyc;
      end
      if (done_strobe) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      held_v = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    arb_in_rtr = rnd_rtr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic vec_t mk(int h, int w, logic [15:0] a, int l, logic [3:0] r, logic [3:0] g,
                              logic [3:0] b, bit o, bit rn, int n, logic [15:0] la,
                              logic [31:0] ld, logic [3:0] lw);
    vec_t v;
    v.hgt = h; v.wid = w; v.addr = a; v.lane = l; v.r = r; v.g = g; v.b = b;
    v.outline = o; v.rnd = rn; v.nwr = n; v.laddr = la; v.ldata = ld; v.lwben = lw;
    return v;
  endfunction

  task automatic build_exp(input vec_t v);
    logic [3:0] c;
    exp_q.delete();
    for (int r = 0; r < v.hgt; r++)
      for (int k = 0; k < v.wid; k++) begin
        if (v.outline && r > 0 && r < v.hgt - 1 && k > 0 && k < v.wid - 1) continue;
        for (int p = 0; p < 3; p++) begin
          int pos = v.lane + k;
          int ln  = pos % 8;
          c = (p == 0) ? v.r : (p == 1) ? v.g : v.b;
          exp_q.push_back(wr(16'(v.addr + 16'(r * 240) + 16'((pos / 8) * 3) + 16'(p)),
                             32'(c) << (ln * 4), 4'(1 << ((ln * 4) / 8))));
        end
      end
  endtask

  task automatic start_cmd(input vec_t v);
    int n = 0;
    while (!out_rtr && n < 50) begin @(negedge clk); n++; end
    chk("rtr_wait", out_rtr, 1);
    @(posedge clk); #2;
    init_addr = v.addr; init_lane = 3'(v.lane);
    cmd_data_hgt = 16'(v.hgt); cmd_data_wid = 16'(v.wid);
    cmd_data_rval = v.r; cmd_data_gval = v.g; cmd_data_bval = v.b;
    cmd_outline = v.outline; in_rts = 1'b1;
    @(posedge clk); #2;
    in_rts = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", done_cnt, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    vecs[0] = mk(2, 3,  16'h0100, 0, 4'hA, 4'h5, 4'h3, 0, 0, 18, 16'h01F2, 32'h0000_0300, 4'b0010);
    vecs[1] = mk(2, 3,  16'h0100, 0, 4'hA, 4'h5, 4'h3, 0, 1, 18, 16'h01F2, 32'h0000_0300, 4'b0010);
    vecs[2] = mk(1, 10, 16'h0000, 6, 4'h1, 4'h2, 4'h3, 0, 1, 30, 16'h0005, 32'h3000_0000, 4'b1000);
    vecs[3] = mk(4, 4,  16'h0200, 0, 4'hF, 4'hE, 4'hD, 1, 0, 36, 16'h04D2, 32'h0000_D000, 4'b0010);
    vecs[4] = mk(3, 1,  16'h0010, 5, 4'h1, 4'h2, 4'h3, 1, 1, 9,  16'h01F2, 32'h0030_0000, 4'b0100);
    vecs[5] = mk(2, 1,  16'hFFFE, 7, 4'h1, 4'h2, 4'h3, 0, 0, 6,  16'h00F0, 32'h3000_0000, 4'b1000);
    vecs[6] = mk(2, 5,  16'h0000, 0, 4'h1, 4'h2, 4'h3, 1, 0, 30, 16'h00F2, 32'h0003_0000, 4'b0100);
    vecs[7] = mk(5, 3,  16'h0000, 0, 4'h1, 4'h2, 4'h3, 1, 1, 36, 16'h03C2, 32'h0000_0300, 4'b0010);

    // Reset values and first ready.
    repeat (2) @(negedge clk);
    chk("rst_rts", arb_out_rts, 0);
    chk("rst_op", arb_out_op, 0);
    chk("rst_rtr", out_rtr, 0);
    chk("rst_done", done_strobe, 0);
    chk("rst_outs", wr(arb_out_addr, arb_out_data, arb_out_wben), 0);
    @(posedge clk); #2 rst_ = 1'b1;
    @(negedge clk); chk("rel_rtr0", out_rtr, 0);
    @(negedge clk); chk("rel_rtr1", out_rtr, 1);

    // Reset in the middle of a 4x4 fill.
    obs_q.delete(); done_cnt = 0;
    start_cmd(mk(4, 4, 16'h0300, 0, 4'h1, 4'h2, 4'h3, 0, 0, 0, 0, 0, 0));
    n = 0;
    while (obs_q.size() < 5 && n < 100) begin @(negedge clk); #1; n++; end
    chk("mid_xfc", obs_q.size(), 5);
    rst_ = 1'b0;
    #1;
    chk("mid_rst_rts", arb_out_rts, 0);
    chk("mid_rst_op", arb_out_op, 0);
    chk("mid_rst_rtr", out_rtr, 0);
    @(posedge clk); #2 rst_ = 1'b1;
    @(negedge clk); chk("mid_rel_rtr0", out_rtr, 0);
    chk("mid_rel_rts", arb_out_rts, 0);
    @(negedge clk); chk("mid_rel_rtr1", out_rtr, 1);
    chk("mid_no_more", obs_q.size(), 5);

    // Table-driven fills against the reference model and hand-computed last writes.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      build_exp(v);
      obs_q.delete(); done_cnt = 0;
      rnd_rtr = v.rnd;
      start_cmd(v);
      wait_done();
      rnd_rtr = 0;
      chk($sformatf("v%0d_nwr", i), obs_q.size(), v.nwr);
      chk($sformatf("v%0d_model_n", i), exp_q.size(), v.nwr);
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
        chk($sformatf("v%0d_w%0d", i, k), obs_q[k], exp_q[k]);
      if (obs_q.size() > 0)
        chk($sformatf("v%0d_last", i), obs_q[obs_q.size() - 1], wr(v.laddr, v.ldata, v.lwben));
      chk($sformatf("v%0d_done_lat", i), done_cyc - last_xfc_cyc, 1);
      if (i == 0 && obs_q.size() >= 10) begin
        chk("v0_w0", obs_q[0], wr(16'h0100, 32'hA, 4'b0001));
        chk("v0_w1", obs_q[1], wr(16'h0101, 32'h5, 4'b0001));
        chk("v0_w2", obs_q[2], wr(16'h0102, 32'h3, 4'b0001));
        chk("v0_w3", obs_q[3], wr(16'h0100, 32'hA0, 4'b0001));
        chk("v0_w6", obs_q[6], wr(16'h0100, 32'hA00, 4'b0010));
        chk("v0_row1", obs_q[9], wr(16'h01F0, 32'hA, 4'b0001));
      end
      if (i == 2 && obs_q.size() >= 7) begin
        chk("v2_w0", obs_q[0], wr(16'h0000, 32'h0100_0000, 4'b1000));
        chk("v2_w3", obs_q[3], wr(16'h0000, 32'h1000_0000, 4'b1000));
        chk("v2_w6", obs_q[6], wr(16'h0003, 32'h0000_0001, 4'b0001));
      end
    end

    // Zero height, then a back-to-back command with in_rts held high.
    obs_q.delete(); done_cnt = 0;
    n = 0;
    while (!out_rtr && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    cmd_data_hgt = 16'd0; cmd_data_wid = 16'd3; cmd_outline = 1'b0; in_rts = 1'b1;
    @(negedge clk);
    chk("z_pre_done", done_strobe, 0);
    chk("z_pre_rtr", out_rtr, 1);
    @(posedge clk); #2;
    cmd_data_hgt = 16'd1; cmd_data_wid = 16'd1; init_addr = 16'h0040; init_lane = 3'd0;
    cmd_data_rval = 4'h7; cmd_data_gval = 4'h8; cmd_data_bval = 4'h9;
    @(negedge clk);
    chk("z_done", done_strobe, 1);
    chk("z_rts", arb_out_rts, 0);
    chk("z_rtr_low", out_rtr, 0);
    @(negedge clk);
    chk("z_idle_rtr", out_rtr, 1);
    chk("z_idle_done", done_strobe, 0);
    chk("z_no_writes", obs_q.size(), 0);
    @(posedge clk); #2 in_rts = 1'b0;
    @(negedge clk);
    chk("z2_rts", arb_out_rts, 1);
    chk("z2_rtr", out_rtr, 0);
    chk("z2_addr", arb_out_addr, 16'h0040);
    done_cnt = 0;
    wait_done();
    chk("z2_nwr", obs_q.size(), 3);
    if (obs_q.size() == 3)
      chk("z2_last", obs_q[2], wr(16'h0042, 32'h9, 4'b0001));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
